// File: rtl/ula_pkg.sv
// Shared definitions for the ULA operand staging path: default widths,
// source index map and the stage state encoding.
package ula_pkg;

   localparam int ULA_DATA_W = 32;

   localparam int SRC_PC  = 0;
   localparam int SRC_MDR = 1;
   localparam int SRC_A   = 2;
   localparam int SRC_B   = 3;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } stage_state_e;

endpackage

// File: rtl/ula_operand_stage_if.sv
// Capture/consume handshake between the control unit, the operand stage and the ULA.
interface ula_operand_stage_if
   import ula_pkg::*;
#(
   parameter int DATA_W = ULA_DATA_W
) ();

   logic              load;
   logic              load_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              op_valid;
   logic              op_ack;

   modport master (
      output load,
      output op_ack,
      input  load_ready,
      input  op_a,
      input  op_b,
      input  op_valid
   );

   modport slave (
      input  load,
      input  op_ack,
      output load_ready,
      output op_a,
      output op_b,
      output op_valid
   );

endinterface

// File: rtl/ula_operand_stage_src_select.sv
// NUM_SRC:1 combinational source mux; an out-of-range index yields zero
// and raises oor_o.
module src_select
   import ula_pkg::*;
#(
   parameter int DATA_W  = ULA_DATA_W,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC*DATA_W-1:0] src_flat_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [DATA_W-1:0]         data_o,
   output logic                      oor_o
);

   always_comb begin
      // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
      data_o = '0;
      oor_o  = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel_i == SEL_W'(i)) begin
            data_o = src_flat_i[i*DATA_W +: DATA_W];
            oor_o  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/ula_operand_stage.sv
// ULA operand selector plus one-entry holding register with a load/ack
// handshake, sticky error flags and a wrapping capture counter.
module ula_operand_stage
   import ula_pkg::*;
#(
   parameter int DATA_W  = ULA_DATA_W,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1,
   parameter int CNT_W   = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*DATA_W-1:0] src_flat,
   input  logic [SEL_W-1:0]          sel_a,
   input  logic [SEL_W-1:0]          sel_b,
   input  logic                      clr_err,
   output logic                      err_sel,
   output logic                      err_ovf,
   output logic [CNT_W-1:0]          cap_count,
   ula_operand_stage_if.slave        stage_if
);

   localparam logic [0:0] ST_EMPTY = 1'(EMPTY);
   localparam logic [0:0] ST_FULL  = 1'(FULL);

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_sel_q, err_sel_d;
   logic              err_ovf_q, err_ovf_d;

   logic [DATA_W-1:0] mux_a, mux_b;
   logic              oor_a, oor_b;
   logic              load_ready;
   logic              capture;

   src_select #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_sel_a (
      .src_flat_i (src_flat),
      .sel_i      (sel_a),
      .data_o     (mux_a),
      .oor_o      (oor_a)
   );

   src_select #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_sel_b (
      .src_flat_i (src_flat),
      .sel_i      (sel_b),
      .data_o     (mux_b),
      .oor_o      (oor_b)
   );

   // An ack frees the slot in the same cycle, allowing back-to-back captures.
   assign load_ready = (state_q == ST_EMPTY) | stage_if.op_ack;
   assign capture    = stage_if.load & load_ready;

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      cnt_d   = cnt_q;
      if (capture) begin
         state_d = ST_FULL;
         op_a_d  = mux_a;
         op_b_d  = mux_b;
         cnt_d   = cnt_q + CNT_W'(1);
      end else if (state_q == ST_FULL && stage_if.op_ack) begin
         state_d = ST_EMPTY;
      end
   end

   // A set event in the same cycle takes priority over clr_err.
   assign err_sel_d = (capture & (oor_a | oor_b)) | (err_sel_q & ~clr_err);
   assign err_ovf_d = (stage_if.load & ~load_ready) | (err_ovf_q & ~clr_err);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_EMPTY;
         op_a_q    <= '0;
         op_b_q    <= '0;
         cnt_q     <= '0;
         err_sel_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         cnt_q     <= cnt_d;
         err_sel_q <= err_sel_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   assign stage_if.load_ready = load_ready;
   assign stage_if.op_a       = op_a_q;
   assign stage_if.op_b       = op_b_q;
   assign stage_if.op_valid   = (state_q == ST_FULL);
   assign err_sel             = err_sel_q;
   assign err_ovf             = err_ovf_q;
   assign cap_count           = cnt_q;

endmodule

// File: tb/tb_ula_operand_stage.sv
// Directed bench: default instance (4 sources, 8-bit counter) and a narrow
// instance (3 sources, 2-bit counter) for out-of-range selects and wrap.
module tb_ula_operand_stage;

   logic clk;
   logic reset;

   // Instance 0: NUM_SRC=4, CNT_W=8
   logic [127:0] src0;
   logic [1:0]   sel_a0, sel_b0;
   logic         clr0, err_sel0, err_ovf0;
   logic [7:0]   cnt0;
   ula_operand_stage_if #(.DATA_W(32)) if0 ();

   // Instance 1: NUM_SRC=3, CNT_W=2
   logic [95:0]  src1;
   logic [1:0]   sel_a1, sel_b1;
   logic         clr1, err_sel1, err_ovf1;
   logic [1:0]   cnt1;
   ula_operand_stage_if #(.DATA_W(32)) if1 ();

   int checks   = 0;
   int failures = 0;

   ula_operand_stage #(.DATA_W(32), .NUM_SRC(4), .CNT_W(8)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .src_flat  (src0),
      .sel_a     (sel_a0),
      .sel_b     (sel_b0),
      .clr_err   (clr0),
      .err_sel   (err_sel0),
      .err_ovf   (err_ovf0),
      .cap_count (cnt0),
      .stage_if  (if0)
   );

   ula_operand_stage #(.DATA_W(32), .NUM_SRC(3), .CNT_W(2)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .src_flat  (src1),
      .sel_a     (sel_a1),
      .sel_b     (sel_b1),
      .clr_err   (clr1),
      .err_sel   (err_sel1),
      .err_ovf   (err_ovf1),
      .cap_count (cnt1),
      .stage_if  (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      reset = 1'b1;
      src0 = {32'h0000_0022, 32'h0000_0011, 32'h8C08_0004, 32'h0040_0000};
      src1 = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
      sel_a0 = '0; sel_b0 = '0; clr0 = 1'b0;
      sel_a1 = '0; sel_b1 = '0; clr1 = 1'b0;
      if0.load = 1'b0; if0.op_ack = 1'b0;
      if1.load = 1'b0; if1.op_ack = 1'b0;
      #12;
      checks++;
      if ({if0.op_valid, if0.load_ready, err_sel0, err_ovf0} !== 4'b0100) begin
         failures++;
         $display("FAIL reset_flags0: got %b want 0100", {if0.op_valid, if0.load_ready, err_sel0, err_ovf0});
      end
      checks++;
      if ({if0.op_a, if0.op_b, cnt0} !== 72'h0) begin
         failures++;
         $display("FAIL reset_data0: op_a=%h op_b=%h cnt=%0d want all 0", if0.op_a, if0.op_b, cnt0);
      end
      checks++;
      if ({if1.op_valid, if1.load_ready, err_sel1, err_ovf1, cnt1} !== 6'b010000) begin
         failures++;
         $display("FAIL reset_state1: got %b want 010000", {if1.op_valid, if1.load_ready, err_sel1, err_ovf1, cnt1});
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({if0.op_valid, cnt0} !== 9'h0) begin
         failures++;
         $display("FAIL idle0: op_valid=%b cnt=%0d want 0/0", if0.op_valid, cnt0);
      end
   endtask

   task automatic test_basic_capture;
      sel_a0 = 2'd0; sel_b0 = 2'd3; if0.load = 1'b1;
      @(negedge clk);
      if0.load = 1'b0;
      checks++;
      if ({if0.op_valid, if0.op_a, if0.op_b} !== {1'b1, 32'h0040_0000, 32'h0000_0022}) begin
         failures++;
         $display("FAIL basic_capture: valid=%b a=%h b=%h want 1 00400000 00000022", if0.op_valid, if0.op_a, if0.op_b);
      end
      checks++;
      if ({cnt0, if0.load_ready} !== {8'd1, 1'b0}) begin
         failures++;
         $display("FAIL basic_cnt_ready: cnt=%0d ready=%b want 1/0", cnt0, if0.load_ready);
      end
      src0 = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0};
      sel_a0 = 2'd1; sel_b0 = 2'd2;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({if0.op_valid, if0.op_a, if0.op_b} !== {1'b1, 32'h0040_0000, 32'h0000_0022}) begin
         failures++;
         $display("FAIL basic_hold: valid=%b a=%h b=%h want 1 00400000 00000022", if0.op_valid, if0.op_a, if0.op_b);
      end
      src0 = {32'h0000_0022, 32'h0000_0011, 32'h8C08_0004, 32'h0040_0000};
   endtask

   task automatic test_back_to_back;
      sel_a0 = 2'd2; sel_b0 = 2'd1;
      if0.op_ack = 1'b1; if0.load = 1'b1;
      #1;
      checks++;
      if (if0.load_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready: got %b want 1", if0.load_ready);
      end
      @(negedge clk);
      if0.op_ack = 1'b0; if0.load = 1'b0;
      checks++;
      if ({if0.op_valid, if0.op_a, if0.op_b, cnt0} !== {1'b1, 32'h0000_0011, 32'h8C08_0004, 8'd2}) begin
         failures++;
         $display("FAIL b2b_capture: valid=%b a=%h b=%h cnt=%0d want 1 00000011 8c080004 2", if0.op_valid, if0.op_a, if0.op_b, cnt0);
      end
   endtask

   task automatic test_overflow;
      sel_a0 = 2'd0; sel_b0 = 2'd0; if0.load = 1'b1;
      #1;
      checks++;
      if (if0.load_ready !== 1'b0) begin
         failures++;
         $display("FAIL ovf_ready: got %b want 0", if0.load_ready);
      end
      @(negedge clk);
      if0.load = 1'b0;
      checks++;
      if ({err_ovf0, err_sel0, if0.op_a, if0.op_b, cnt0} !== {1'b1, 1'b0, 32'h0000_0011, 32'h8C08_0004, 8'd2}) begin
         failures++;
         $display("FAIL ovf_drop: ovf=%b sel=%b a=%h b=%h cnt=%0d want 1 0 00000011 8c080004 2", err_ovf0, err_sel0, if0.op_a, if0.op_b, cnt0);
      end
      @(negedge clk);
      checks++;
      if (err_ovf0 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky: got %b want 1", err_ovf0);
      end
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      checks++;
      if (err_ovf0 !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: got %b want 0", err_ovf0);
      end
      if0.op_ack = 1'b1;
      @(negedge clk);
      if0.op_ack = 1'b0;
      checks++;
      if ({if0.op_valid, if0.load_ready, if0.op_a, if0.op_b} !== {1'b0, 1'b1, 32'h0000_0011, 32'h8C08_0004}) begin
         failures++;
         $display("FAIL drain_hold: valid=%b ready=%b a=%h b=%h want 0 1 00000011 8c080004", if0.op_valid, if0.load_ready, if0.op_a, if0.op_b);
      end
   endtask

   task automatic test_out_of_range;
      sel_a1 = 2'd1; sel_b1 = 2'd3; if1.load = 1'b1; clr1 = 1'b1;
      @(negedge clk);
      if1.load = 1'b0;
      checks++;
      if ({if1.op_valid, if1.op_a, if1.op_b, cnt1} !== {1'b1, 32'h0000_0022, 32'h0000_0000, 2'd1}) begin
         failures++;
         $display("FAIL oor_capture: valid=%b a=%h b=%h cnt=%0d want 1 00000022 00000000 1", if1.op_valid, if1.op_a, if1.op_b, cnt1);
      end
      checks++;
      if (err_sel1 !== 1'b1) begin
         failures++;
         $display("FAIL oor_set_beats_clr: got %b want 1", err_sel1);
      end
      if1.op_ack = 1'b1;
      @(negedge clk);
      if1.op_ack = 1'b0; clr1 = 1'b0;
      checks++;
      if ({err_sel1, if1.op_valid} !== 2'b00) begin
         failures++;
         $display("FAIL oor_clear: err_sel=%b valid=%b want 0 0", err_sel1, if1.op_valid);
      end
   endtask

   task automatic test_wrap_and_async_reset;
      // Three more captures on top of the one above: 4 mod 4 = 0.
      sel_a1 = 2'd2; sel_b1 = 2'd2;
      if1.load = 1'b1; if1.op_ack = 1'b1;
      repeat (3) @(negedge clk);
      if1.load = 1'b0; if1.op_ack = 1'b0;
      checks++;
      if ({cnt1, if1.op_valid, err_sel1} !== {2'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL wrap: cnt=%0d valid=%b err_sel=%b want 0 1 0", cnt1, if1.op_valid, err_sel1);
      end
      checks++;
      if ({if1.op_a, if1.op_b} !== {32'h0000_0033, 32'h0000_0033}) begin
         failures++;
         $display("FAIL same_sel: a=%h b=%h want 00000033 00000033", if1.op_a, if1.op_b);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({if1.op_valid, if1.load_ready, if1.op_a, if1.op_b} !== {1'b0, 1'b1, 64'h0}) begin
         failures++;
         $display("FAIL async_reset: valid=%b ready=%b a=%h b=%h want 0 1 0 0", if1.op_valid, if1.load_ready, if1.op_a, if1.op_b);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_back_to_back();
      test_overflow();
      test_out_of_range();
      test_wrap_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
